seg_display_sched: RTL and testbench
====================================

# seg_display_sched

Time-slicing scheduler that shares the single seven-segment display between two hex-digit requesters (A and B). Each requester posts a 4-bit value over a req/ack handshake. The block round-robins the display between sources holding a valid value, giving each a fixed dwell period, and drives the decoded segments plus a source-indicator dot. It sits between the user logic (e.g. the seconds counter and a status source) and the `io_out` segment pins.

## Interface
- `DWELL`, 10_000_000: display cycles per slot (≥2); sim benches use 4.
- `BLANK`, 4: blank cycles between slots (≥1); used only with `SEG_SCHED_BLANK_GAP_EN`.
- `clk` in 1: the only clock; every register updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on `clk`.
- `req_a` in 1: requester A has a new value on `data_a`.
- `data_a` in 4: hex digit from A; must be stable while `req_a` is high.
- `ack_a` out 1: one-cycle accept pulse to A.
- `req_b` in 1, `data_b` in 4, `ack_b` out 1: same as A, for requester B.
- `segments` out 7: decoded segments, active-high; bit0 = seg a … bit6 = seg g.
- `dp` out 1: high while B owns the display.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Accept handshake, per source X:
  - `ack_x` (registered) = `req_x & ~ack_x`.
  - On the edge that raises `ack_x`, `data_x` is captured into `hold_x` and `valid_x` is set to 1.
  - A requester holding `req_x` high is acked every other cycle, and each ack recaptures the data.
  - A and B are accepted independently and may be acked in the same cycle.
  - `valid_x` stays set until reset.
- State machine IDLE / SHOW / GAP:
  - Registers: `owner` (A or B), `cnt` (width = clog2 of max(DWELL, BLANK)), display latch `disp`.
  - **IDLE**: `segments` = 0 and `dp` = 0. When `valid_a | valid_b`, go to SHOW. `owner` = A if `valid_a`, else B; `cnt` = 0; `disp` = `hold_owner`.
  - **SHOW**:
    - `segments` = hexdecode(`disp`); `dp` = (`owner` == B).
    - `cnt` increments each cycle.
    - When `cnt` == DWELL−1, the slot ends and `cnt` = 0.
    - Next owner at slot end: the other source if its `valid` is set, otherwise the same source.
  - **GAP** (macro enabled only): `segments` = 0, `dp` = 0 for BLANK cycles, then SHOW with the next owner.
  - Without the macro, slot end goes directly to SHOW with the next owner.
- `disp` loads `hold_owner` only on entry to SHOW. A value accepted mid-slot appears at the next slot of that source, never mid-slot.
- Hex decode, in hex with bit0 = a:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
- The next-owner choice is evaluated in the slot-end cycle. A value accepted in that same cycle counts as valid.

## Timing
- Reset values: `segments` = 0, `dp` = 0, `ack_a` = `ack_b` = 0, `busy` = 0. State = IDLE, `owner` = A, `cnt` = 0, `valid_*` = 0, `hold_*` = 0, `disp` = 0.
- `req` and `data` are ignored in any cycle where `rst_n` is low.
- Reset asserted mid-slot or mid-handshake: all outputs take their reset values at the next edge. An in-flight ack is dropped.
- Ack latency: `req_x` high at edge N → `ack_x` high after edge N+1, low after N+2 (if `req` is still high, high again after N+3).
- First display: `ack_x` at edge N sets `valid_x` at N; IDLE→SHOW at edge N+1. `segments` are valid from N+1.
- Slot length is exactly DWELL cycles. With the macro, the gap is exactly BLANK cycles.
- All outputs are registered or decoded from registers only. No combinational path from inputs to outputs.

## Configuration
- `SEG_SCHED_BLANK_GAP_EN` defined:
  - The GAP state and `BLANK` parameter are compiled in.
  - Every slot boundary, including a same-owner repeat, inserts BLANK blank cycles.
- Undefined:
  - No GAP state; `BLANK` is unused.
  - Period per slot = DWELL exactly, with back-to-back slots.

## Test plan
- Reset, then idle 20 cycles with no req → `segments` = 0, `dp` = 0, `busy` = 0, no ack.
- Single source: `req_a` pulse with `data_a` = 5 → `ack_a` after 1 cycle. Next edge: `segments` = 6D, `dp` = 0, held indefinitely, with a DWELL-period same-owner repeat (blanked only with the macro).
- Round robin, DWELL = 4, BLANK = 2:
  - Setup: A = 3, B = 0xE, accepted in the same cycle.
  - Response: 4 cycles of 4F/dp 0, [2 cycles of 0], then 4 cycles of 79/dp 1, repeating.
  - Check every boundary count with and without the macro.
- Mid-slot update: during an A slot showing 1 (06), post A = 8 → 06 held to slot end. The next A slot shows 7F.
- Held req: `req_b` high for 6 cycles → `ack_b` toggles 1,0,1,0,1,0 from cycle 1. `hold_b` equals `data_b` at the last ack.
- Reset mid-slot (`rst_n` low 1 cycle during a B slot) → all outputs at reset values next edge. Valid flags cleared, so the display stays blank until a new req.

Source files
------------

// File: rtl/seg_display_sched.sv
// Time-slices one seven-segment display between hex requesters A and B (optional blank gap: SEG_SCHED_BLANK_GAP_EN).
// Latency: ack one cycle after req is sampled; first digit shown the cycle after the ack; DWELL cycles per slot.
// Backpressure: a held req is acked every other cycle; requesters never stall, newer values overwrite the held digit.
module seg_display_sched #(
  parameter int DWELL = 10_000_000,
  parameter int BLANK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic [3:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [3:0] data_b,
  output logic       ack_b,
  output logic [6:0] segments,
  output logic       dp,
  output logic       busy
);

  localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
`ifdef SEG_SCHED_BLANK_GAP_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
`endif

`ifdef SEG_SCHED_BLANK_GAP_EN
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

  // owner encoding: 0 = A, 1 = B (so dp is simply owner while showing)
  state_t          state, state_nxt;
  logic            owner, owner_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      disp, disp_nxt;
  logic [3:0]      hold_a, hold_b;
  logic            valid_a, valid_b;
  logic            next_owner;

  function automatic logic [6:0] hexdec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Accept handshakes: ack toggles while req is held, each ack latches the digit and marks the source live.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      hold_a  <= 4'h0;
      hold_b  <= 4'h0;
    end else begin
      ack_a <= req_a & ~ack_a;
      ack_b <= req_b & ~ack_b;
      if (req_a & ~ack_a) begin
        hold_a  <= data_a;
        valid_a <= 1'b1;
      end
      if (req_b & ~ack_b) begin
        hold_b  <= data_b;
        valid_b <= 1'b1;
      end
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      cnt   <= '0;
      disp  <= 4'h0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      disp  <= disp_nxt;
    end
  end

  // Next-state: round-robin to the other source only if it has ever posted; disp latches only on SHOW entry.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    disp_nxt   = disp;
    next_owner = owner ? ~valid_a : valid_b;
    case (state)
      IDLE: begin
        if (valid_a | valid_b) begin
          state_nxt = SHOW;
          owner_nxt = ~valid_a;
          cnt_nxt   = '0;
          disp_nxt  = valid_a ? hold_a : hold_b;
        end
      end
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_nxt   = '0;
          owner_nxt = next_owner;
`ifdef SEG_SCHED_BLANK_GAP_EN
          state_nxt = GAP;
`else
          disp_nxt  = next_owner ? hold_b : hold_a;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef SEG_SCHED_BLANK_GAP_EN
      GAP: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SHOW;
          disp_nxt  = owner ? hold_b : hold_a;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from registers only; blank whenever not showing.
  always_comb begin
    segments = 7'h00;
    dp       = 1'b0;
    busy     = (state != IDLE);
    if (state == SHOW) begin
      segments = hexdec(disp);
      dp       = owner;
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
module tb_seg_display_sched;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
`ifdef SEG_SCHED_BLANK_GAP_EN
  localparam int G = BLANK;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [3:0] data_a = 4'h0, data_b = 4'h0;
  logic       ack_a, ack_b, dp, busy;
  logic [6:0] segments;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display_sched #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .segments(segments), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: per-source accept state plus a queue of upcoming {dp,segments} cycles.
  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit         mv_a, mv_b, mack_a, mack_b, mbusy, mowner, mgap;
  logic [3:0] mh_a, mh_b;
  logic [7:0] q[$];
  logic [7:0] mout;

  task automatic push_show();
    for (int i = 0; i < DWELL; i++) q.push_back({mowner, dec_tab[mowner ? mh_b : mh_a]});
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      mv_a = 0; mv_b = 0; mack_a = 0; mack_b = 0; mbusy = 0; mowner = 0; mgap = 0;
      mh_a = 0; mh_b = 0; q.delete(); mout = 8'h00;
    end else begin
      if (q.size() == 0) begin
        if (!mbusy) begin
          if (mv_a | mv_b) begin
            mowner = !mv_a;
            mbusy = 1;
            push_show();
          end
        end else if (mgap) begin
          mgap = 0;
          push_show();
        end else begin
          mowner = mowner ? !mv_a : mv_b;
`ifdef SEG_SCHED_BLANK_GAP_EN
          repeat (BLANK) q.push_back(8'h00);
          mgap = 1;
`else
          push_show();
`endif
        end
      end
      mout = (q.size() > 0) ? q.pop_front() : 8'h00;
      if (req_a && !mack_a) begin mh_a = data_a; mv_a = 1; mack_a = 1; end else mack_a = 0;
      if (req_b && !mack_b) begin mh_b = data_b; mv_b = 1; mack_b = 1; end else mack_b = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {busy, ack_b, ack_a, dp, segments};
  endfunction

  function automatic logic [10:0] expv();
    return {mbusy, mack_b, mack_a, mout};
  endfunction

  task automatic apply_reset();
    rst_n = 0; req_a = 0; req_b = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      req_a = 1'($urandom); req_b = 1'($urandom);
      data_a = 4'($urandom); data_b = 4'($urandom);
      tick();
      n_checks++;
      if (obs() !== 11'h000) begin
        n_fail++; $display("FAIL reset_hold cyc %0d got %h want 000", i, obs());
      end
    end
    rst_n = 1; req_a = 0; req_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (obs() !== 11'h000 || obs() !== expv()) begin
        n_fail++; $display("FAIL idle cyc %0d got %h want 000", i, obs());
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_a = 1; data_a = 4'h5;
    tick();
    n_checks++;
    if (ack_a !== 1'b1 || obs() !== expv()) begin
      n_fail++; $display("FAIL single_ack got ack_a=%b obs=%h want ack 1 obs=%h", ack_a, obs(), expv());
    end
    req_a = 0;
    tick();
    n_checks++;
    if (segments !== 7'h6D || dp !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_first got seg=%h dp=%b busy=%b want 6d 0 1", segments, dp, busy);
    end
    for (int i = 1; i < 3 * (DWELL + G); i++) begin
      tick();
      n_checks++;
      if (obs() !== expv() || ((i % (DWELL + G)) < DWELL && segments !== 7'h6D)) begin
        n_fail++; $display("FAIL single_hold cyc %0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] want;
    int p;
    apply_reset();
    req_a = 1; data_a = 4'h3; req_b = 1; data_b = 4'hE;
    tick();
    req_a = 0; req_b = 0;
    for (int i = 0; i < 3 * 2 * (DWELL + G); i++) begin
      tick();
      p = i % (2 * (DWELL + G));
      if (p < DWELL) want = {1'b0, 7'h4F};
      else if (p < DWELL + G) want = 8'h00;
      else if (p < 2 * DWELL + G) want = {1'b1, 7'h79};
      else want = 8'h00;
      n_checks++;
      if ({dp, segments} !== want || obs() !== expv()) begin
        n_fail++; $display("FAIL round_robin cyc %0d got %h want %h (model %h)", i, {dp, segments}, want, expv());
      end
    end
  endtask

  task automatic test_mid_slot();
    apply_reset();
    req_a = 1; data_a = 4'h1;
    tick();
    req_a = 0;
    tick();
    tick();
    req_a = 1; data_a = 4'h8;
    tick();
    req_a = 0;
    n_checks++;
    if (segments !== 7'h06 || ack_a !== 1'b1) begin
      n_fail++; $display("FAIL mid_accept got seg=%h ack=%b want 06 1", segments, ack_a);
    end
    tick();
    n_checks++;
    if (segments !== 7'h06) begin
      n_fail++; $display("FAIL mid_hold got %h want 06", segments);
    end
    repeat (G) tick();
    tick();
    n_checks++;
    if (segments !== 7'h7F || obs() !== expv()) begin
      n_fail++; $display("FAIL mid_next got %h want 7f", segments);
    end
    for (int i = 0; i < 2 * (DWELL + G); i++) begin
      tick();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL mid_after cyc %0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_held_req();
    logic [5:0] pat;
    pat = 6'b010101;
    apply_reset();
    req_b = 1; data_b = 4'h9;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (ack_b !== pat[i] || obs() !== expv()) begin
        n_fail++; $display("FAIL held_ack cyc %0d got %b want %b", i, ack_b, pat[i]);
      end
    end
    req_b = 0;
    for (int i = 0; i < 2 * (DWELL + G); i++) begin
      tick();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL held_show cyc %0d got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_a = 1; data_a = 4'h3; req_b = 1; data_b = 4'hE;
    tick();
    req_a = 0; req_b = 0;
    repeat (DWELL + G + 2) tick();
    n_checks++;
    if (dp !== 1'b1 || segments !== 7'h79) begin
      n_fail++; $display("FAIL rst_mid_pre got dp=%b seg=%h want 1 79", dp, segments);
    end
    rst_n = 0; req_a = 1;
    tick();
    rst_n = 1; req_a = 0;
    n_checks++;
    if (obs() !== 11'h000) begin
      n_fail++; $display("FAIL rst_mid got %h want 000", obs());
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (obs() !== 11'h000 || obs() !== expv()) begin
        n_fail++; $display("FAIL rst_mid_blank cyc %0d got %h want 000", i, obs());
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      if (!req_a) begin
        if ($urandom_range(0, 7) == 0) begin req_a = 1; data_a = 4'($urandom); end
      end else if ($urandom_range(0, 1) == 0) req_a = 0;
      if (!req_b) begin
        if ($urandom_range(0, 7) == 0) begin req_b = 1; data_b = 4'($urandom); end
      end else if ($urandom_range(0, 1) == 0) req_b = 0;
      tick();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random cyc %0d got %h want %h", i, obs(), expv());
      end
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mid_slot();
    test_held_req();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
